// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter: FSM state
//   encoding, the instruction substituted on a fetch timeout, and default
//   values for the starvation and bus-timeout limits.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_IF_BUSY = 3'd1,
        ARB_DM_BUSY = 3'd2,
        ARB_IF_DROP = 3'd3,
        ARB_RESP    = 3'd4
    } arb_state_e;

    // addi x0, x0, 0 -- returned to fetch when the bus never answers
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned ARB_STARVE_LIMIT = 4;
    localparam int unsigned ARB_TIMEOUT      = 64;

    // States in which a bus cycle is owned and mem_req is (or will be) driven
    function automatic logic is_bus_state(input arb_state_e s);
        return (s == ARB_IF_BUSY) || (s == ARB_DM_BUSY) || (s == ARB_IF_DROP);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// arb_wait_counter
//   Saturating up-counter with synchronous clear (priority over enable).
//   at_limit is high while the count equals LIMIT; the count then holds.
// Ports
//   clk      in  system clock, rising edge
//   rst_n    in  async active-low reset, count -> 0
//   clear    in  synchronous clear to 0
//   enable   in  count one step (ignored at the limit)
//   at_limit out count == LIMIT
module arb_wait_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_limit) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        at_limit = (count == W'(LIMIT));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and the
//   MEM-stage load/store path. One requester is granted from IDLE, the bus
//   registers are loaded, mem_req is raised the following cycle and held
//   until mem_ack (or a timeout), and a one-cycle completion pulse is issued
//   from RESP. Data wins arbitration unless IF has been denied STARVE_LIMIT
//   consecutive cycles. A flush during a fetch lets the bus cycle finish but
//   suppresses if_valid.
// Ports
//   clk, rst_n             clock / async active-low reset
//   flush                  IF/ID flush; blocks IF grant in IDLE, drops an IF access in flight
//   if_req/if_addr         fetch request (held until if_valid)
//   if_rdata/if_valid      fetched word and its 1-cycle pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb   load/store request (held until dm_done)
//   dm_rdata/dm_done       load data and its 1-cycle pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   registered bus outputs
//   mem_rdata/mem_ack      bus read data and 1-cycle completion
//   stall_if/stall_mem     pipeline stalls while a request is outstanding
//   err_timeout            sticky bus-timeout flag
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STARVE_LIMIT   = ARB_STARVE_LIMIT,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    stall_if,
    output logic                    stall_mem,
    output logic                    err_timeout
);

    arb_state_e state, state_next;

    logic owner_if;        // 1: current/last access belongs to fetch
    logic grant_if, grant_dm;
    logic ack_hit, timeout_hit;
    logic starve_at_limit, wait_at_limit;
    logic if_served;

    // A bus cycle ends on ack, or on the last allowed mem_req cycle without ack
    always_comb begin
        ack_hit     = mem_req && mem_ack;
        timeout_hit = mem_req && !mem_ack && wait_at_limit;
        if_served   = (state == ARB_IF_BUSY) || (state == ARB_IF_DROP) ||
                      ((state == ARB_RESP) && owner_if);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state / grant ----------------
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (dm_req && (!if_req || !starve_at_limit)) begin
                    grant_dm   = 1'b1;
                    state_next = ARB_DM_BUSY;
                end else if (if_req && !flush) begin
                    grant_if   = 1'b1;
                    state_next = ARB_IF_BUSY;
                end
            end
            ARB_IF_BUSY: begin
                // flush coinciding with completion: finish silently
                if (flush) begin
                    state_next = (ack_hit || timeout_hit) ? ARB_IDLE : ARB_IF_DROP;
                end else if (ack_hit || timeout_hit) begin
                    state_next = ARB_RESP;
                end
            end
            ARB_DM_BUSY: begin
                if (ack_hit || timeout_hit) begin
                    state_next = ARB_RESP;
                end
            end
            ARB_IF_DROP: begin
                if (ack_hit || timeout_hit) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Stalls are gated by rst_n so they drop together with the aborted access
    always_comb begin
        if_valid  = (state == ARB_RESP) && owner_if;
        dm_done   = (state == ARB_RESP) && !owner_if;
        stall_if  = rst_n && if_req && !if_valid;
        stall_mem = rst_n && dm_req && !dm_done;
    end

    // ---------------- bus and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_if    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (grant_dm) begin
                owner_if  <= 1'b0;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_we ? dm_wdata : '0;
                mem_wstrb <= dm_we ? dm_wstrb : '0;
            end else if (grant_if) begin
                owner_if  <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end

            // State is still IDLE on the grant edge, so mem_req rises one cycle later
            mem_req <= is_bus_state(state) && !ack_hit && !timeout_hit;

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end

            if ((state == ARB_IF_BUSY) && !flush) begin
                if (ack_hit) begin
                    if_rdata <= mem_rdata;
                end else if (timeout_hit) begin
                    if_rdata <= DATA_WIDTH'(NOP_INSTR);
                end
            end

            if (state == ARB_DM_BUSY) begin
                if (ack_hit) begin
                    dm_rdata <= mem_rdata;
                end else if (timeout_hit) begin
                    dm_rdata <= '0;
                end
            end
        end
    end

    // ---------------- counters ----------------
    // Consecutive cycles fetch waits while someone else holds the port
    arb_wait_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!if_req || grant_if || if_served),
        .enable   (if_req),
        .at_limit (starve_at_limit)
    );

    // at_limit marks the final permitted mem_req cycle (TIMEOUT_CYCLES in total)
    arb_wait_counter #(
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (grant_if || grant_dm),
        .enable   (mem_req),
        .at_limit (wait_at_limit)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change and outputs are
//   sampled on the falling clock edge; every expected value is written
//   out by hand from the cycle-by-cycle behaviour of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [SW-1:0] dm_wstrb;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          err_timeout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_wstrb    (dm_wstrb),
        .dm_rdata    (dm_rdata),
        .dm_done     (dm_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic nxt(input int unsigned n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Called in the first busy cycle (mem_req still low). Acks on the first
    // mem_req cycle and returns in the RESP cycle.
    task automatic complete(input string tag, input logic [31:0] rd);
        chk1({tag, "_req_lo"}, mem_req, 1'b0);
        nxt();
        chk1({tag, "_req_hi"}, mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        nxt();
        mem_ack = 1'b0;
        chk1({tag, "_req_drop"}, mem_req, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_wstrb  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // ---- reset state ----
        nxt(2);
        if_req = 1'b1;
        nxt();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk ("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_dm_done", dm_done, 1'b0);
        chk1("rst_err", err_timeout, 1'b0);
        chk ("rst_if_rdata", if_rdata, 32'h0);
        chk ("rst_dm_rdata", dm_rdata, 32'h0);
        chk1("rst_stall_if", stall_if, 1'b0);
        if_req = 1'b0;
        rst_n  = 1'b1;
        nxt();

        // ---- 1: single fetch, ack two cycles after mem_req ----
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        nxt();
        chk ("t1_addr", mem_addr, 32'h0000_0100);
        chk1("t1_we", mem_we, 1'b0);
        chk ("t1_wstrb", 32'(mem_wstrb), 32'h0);
        chk1("t1_req_lo", mem_req, 1'b0);
        chk1("t1_stall", stall_if, 1'b1);
        nxt();
        chk1("t1_req_hi", mem_req, 1'b1);
        chk1("t1_stall2", stall_if, 1'b1);
        nxt();
        chk1("t1_req_hold", mem_req, 1'b1);
        chk1("t1_no_valid", if_valid, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        nxt();
        mem_ack = 1'b0;
        chk1("t1_valid", if_valid, 1'b1);
        chk ("t1_rdata", if_rdata, 32'hCAFE_0001);
        chk1("t1_stall_off", stall_if, 1'b0);
        chk1("t1_req_drop", mem_req, 1'b0);
        if_req = 1'b0;
        nxt();
        chk1("t1_valid_pulse", if_valid, 1'b0);
        chk ("t1_rdata_hold", if_rdata, 32'hCAFE_0001);

        // ---- 2: simultaneous fetch and store, data first ----
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_2000;
        dm_wdata = 32'hDEAD_BEEF;
        dm_wstrb = 4'hF;
        nxt();
        chk ("t2_addr", mem_addr, 32'h0000_2000);
        chk1("t2_we", mem_we, 1'b1);
        chk ("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk ("t2_wstrb", 32'(mem_wstrb), 32'hF);
        chk1("t2_stall_mem", stall_mem, 1'b1);
        chk1("t2_stall_if", stall_if, 1'b1);
        complete("t2d", 32'h1111_2222);
        chk1("t2_done", dm_done, 1'b1);
        chk1("t2_no_ifv", if_valid, 1'b0);
        chk1("t2_stall_mem_off", stall_mem, 1'b0);
        chk ("t2_dm_rdata", dm_rdata, 32'h1111_2222);
        dm_req = 1'b0;
        nxt();
        chk1("t2_done_pulse", dm_done, 1'b0);
        chk ("t2_no_b2b", mem_addr, 32'h0000_2000);
        nxt();
        chk ("t2_if_addr", mem_addr, 32'h0000_0200);
        chk1("t2_if_we", mem_we, 1'b0);
        chk ("t2_if_wstrb", 32'(mem_wstrb), 32'h0);
        complete("t2i", 32'h0000_0113);
        chk1("t2_if_valid", if_valid, 1'b1);
        chk ("t2_if_rdata", if_rdata, 32'h0000_0113);
        if_req = 1'b0;
        nxt();

        // ---- 3: starvation; fetch arrives one cycle late ----
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_3000;
        dm_wdata = 32'h0000_0001;
        dm_wstrb = 4'h3;
        nxt();
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        chk ("t3_s1_addr", mem_addr, 32'h0000_3000);
        chk ("t3_s1_wstrb", 32'(mem_wstrb), 32'h3);
        complete("t3s1", 32'hAAAA_0001);
        chk1("t3_s1_done", dm_done, 1'b1);
        dm_addr  = 32'h0000_3004;
        dm_wdata = 32'h0000_0002;
        nxt(2);
        // only 3 denied cycles so far: data still wins
        chk ("t3_s2_addr", mem_addr, 32'h0000_3004);
        chk1("t3_s2_we", mem_we, 1'b1);
        complete("t3s2", 32'hAAAA_0002);
        chk1("t3_s2_done", dm_done, 1'b1);
        dm_addr  = 32'h0000_3008;
        dm_wdata = 32'h0000_0003;
        nxt(2);
        chk ("t3_if_addr", mem_addr, 32'h0000_0300);
        chk1("t3_if_we", mem_we, 1'b0);
        chk1("t3_stall_mem", stall_mem, 1'b1);
        complete("t3i", 32'h0000_0333);
        chk1("t3_if_valid", if_valid, 1'b1);
        chk ("t3_if_rdata", if_rdata, 32'h0000_0333);
        chk1("t3_stall_mem2", stall_mem, 1'b1);
        if_req = 1'b0;
        nxt(2);
        chk ("t3_s3_addr", mem_addr, 32'h0000_3008);
        chk ("t3_s3_wdata", mem_wdata, 32'h0000_0003);
        complete("t3s3", 32'h5555_AAAA);
        chk1("t3_s3_done", dm_done, 1'b1);
        chk ("t3_s3_rdata", dm_rdata, 32'h5555_AAAA);
        dm_req = 1'b0;
        nxt();

        // ---- 4: flush during fetch, then refetch ----
        if_req  = 1'b1;
        if_addr = 32'h0000_0500;
        nxt();
        chk ("t4_addr", mem_addr, 32'h0000_0500);
        flush = 1'b1;
        nxt();
        flush   = 1'b0;
        if_addr = 32'h0000_0040;
        chk1("t4_req_hi", mem_req, 1'b1);
        chk1("t4_no_valid1", if_valid, 1'b0);
        nxt();
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        chk1("t4_no_valid2", if_valid, 1'b0);
        nxt();
        mem_ack = 1'b0;
        chk1("t4_no_valid3", if_valid, 1'b0);
        chk1("t4_req_drop", mem_req, 1'b0);
        chk ("t4_rdata_hold", if_rdata, 32'h0000_0333);
        chk1("t4_stall_if", stall_if, 1'b1);
        nxt();
        chk ("t4_new_addr", mem_addr, 32'h0000_0040);
        complete("t4i", 32'h0000_0093);
        chk1("t4_valid", if_valid, 1'b1);
        chk ("t4_rdata", if_rdata, 32'h0000_0093);
        if_req = 1'b0;
        nxt();

        // flush in IDLE blocks the fetch grant for that cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0060;
        flush   = 1'b1;
        nxt();
        flush = 1'b0;
        chk ("t4_blocked_addr", mem_addr, 32'h0000_0040);
        chk1("t4_blocked_req", mem_req, 1'b0);
        nxt();
        chk ("t4_late_addr", mem_addr, 32'h0000_0060);
        complete("t4j", 32'h0000_6013);
        chk1("t4_late_valid", if_valid, 1'b1);
        chk ("t4_late_rdata", if_rdata, 32'h0000_6013);
        if_req = 1'b0;
        nxt();

        // ---- 5: load timeout (granted despite flush) ----
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_3000;
        flush   = 1'b1;
        nxt();
        flush     = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        chk ("t5_addr", mem_addr, 32'h0000_3000);
        chk1("t5_we", mem_we, 1'b0);
        chk ("t5_wstrb", 32'(mem_wstrb), 32'h0);
        nxt();
        chk1("t5_req_first", mem_req, 1'b1);
        nxt(63);
        chk1("t5_req_last", mem_req, 1'b1);
        chk1("t5_err_pre", err_timeout, 1'b0);
        chk1("t5_done_pre", dm_done, 1'b0);
        nxt();
        chk1("t5_req_drop", mem_req, 1'b0);
        chk1("t5_err", err_timeout, 1'b1);
        chk1("t5_done", dm_done, 1'b1);
        chk ("t5_rdata", dm_rdata, 32'h0);
        chk1("t5_stall_off", stall_mem, 1'b0);
        dm_req = 1'b0;
        nxt();
        mem_ack = 1'b1;
        chk1("t5_done_pulse", dm_done, 1'b0);
        nxt();
        mem_ack = 1'b0;
        chk1("t5_late_req", mem_req, 1'b0);
        chk1("t5_late_done", dm_done, 1'b0);
        chk1("t5_late_ifv", if_valid, 1'b0);
        chk1("t5_err_sticky", err_timeout, 1'b1);
        chk ("t5_rdata_hold", dm_rdata, 32'h0);

        // ---- 6: reset during a data access ----
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_4000;
        dm_wdata = 32'h0000_0044;
        dm_wstrb = 4'hF;
        nxt();
        chk ("t6_addr", mem_addr, 32'h0000_4000);
        nxt();
        chk1("t6_req_hi", mem_req, 1'b1);
        chk1("t6_stall", stall_mem, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_req", mem_req, 1'b0);
        chk1("t6_rst_done", dm_done, 1'b0);
        chk1("t6_rst_stall", stall_mem, 1'b0);
        chk ("t6_rst_addr", mem_addr, 32'h0);
        chk1("t6_rst_err", err_timeout, 1'b0);
        dm_req = 1'b0;
        nxt(2);
        rst_n = 1'b1;
        nxt();
        chk1("t6_post_req", mem_req, 1'b0);
        chk1("t6_post_done", dm_done, 1'b0);
        chk1("t6_post_err", err_timeout, 1'b0);
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_4100;
        nxt();
        chk ("t6_dm_first", mem_addr, 32'h0000_4100);
        complete("t6d", 32'h0000_0077);
        chk1("t6_done", dm_done, 1'b1);
        chk ("t6_rdata", dm_rdata, 32'h0000_0077);
        dm_req = 1'b0;
        nxt(2);
        chk ("t6_if_addr", mem_addr, 32'h0000_0080);
        complete("t6i", 32'h0000_0880);
        chk1("t6_if_valid", if_valid, 1'b1);
        chk ("t6_if_rdata", if_rdata, 32'h0000_0880);
        if_req = 1'b0;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
